hazard_forward_unit: RTL and testbench

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

---
 rtl/hazard_forward_unit_pkg.sv | 10 +
 rtl/fwd_select.sv | 36 +++
 rtl/hazard_forward_unit.sv | 137 +++++++++++++
 tb/tb_hazard_forward_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_forward_unit_pkg.sv
// rtl/hazard_forward_unit_pkg.sv - shared CPU definitions: register address width and operand forwarding codes
package hazard_forward_unit_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - per-operand forwarding priority: EX/MEM result beats MEM/WB result beats register file
module fwd_select
  import hazard_forward_unit_pkg::*;
#(
  parameter int AW = REG_ADDR_W
) (
  input  logic          idex_valid_i,
  input  logic [AW-1:0] src_i,
  input  logic          exmem_valid_i,
  input  logic          exmem_regwrite_i,
  input  logic [AW-1:0] exmem_dst_i,
  input  logic          memwb_valid_i,
  input  logic          memwb_regwrite_i,
  input  logic [AW-1:0] memwb_dst_i,
  output logic [1:0]    sel_o
);

  logic exmem_hit;
  logic memwb_hit;

  // $0 is hardwired, so a write to it never produces a forwardable value
  assign exmem_hit = exmem_valid_i && exmem_regwrite_i && (exmem_dst_i == src_i) && (src_i != '0);
  assign memwb_hit = memwb_valid_i && memwb_regwrite_i && (memwb_dst_i == src_i) && (src_i != '0);

  always_comb begin
    sel_o = FWD_RF;
    if (idex_valid_i) begin
      if (exmem_hit) begin
        sel_o = FWD_MEM;
      end else if (memwb_hit) begin
        sel_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - shadow pipeline tracking ID/EX, EX/MEM, MEM/WB to drive forwarding selects and load-use stalls
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_ADDR_W = hazard_forward_unit_pkg::REG_ADDR_W,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic [REG_ADDR_W-1:0] id_dst_i,
  input  logic                  id_regwrite_i,
  input  logic                  id_memread_i,
  input  logic                  flush_i,
  output logic [1:0]            fwd_a_o,
  output logic [1:0]            fwd_b_o,
  output logic                  stall_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  logic                  idex_valid_q, idex_valid_d;
  logic [REG_ADDR_W-1:0] idex_rs_q, idex_rs_d;
  logic [REG_ADDR_W-1:0] idex_rt_q, idex_rt_d;
  logic [REG_ADDR_W-1:0] idex_dst_q, idex_dst_d;
  logic                  idex_regwrite_q, idex_regwrite_d;
  logic                  idex_memread_q, idex_memread_d;

  logic                  exmem_valid_q, exmem_valid_d;
  logic [REG_ADDR_W-1:0] exmem_dst_q, exmem_dst_d;
  logic                  exmem_regwrite_q, exmem_regwrite_d;

  logic                  memwb_valid_q, memwb_valid_d;
  logic [REG_ADDR_W-1:0] memwb_dst_q, memwb_dst_d;
  logic                  memwb_regwrite_q, memwb_regwrite_d;

  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

  logic                  stall;
  logic                  idex_load;

  // Load in EX whose result the instruction in ID needs; a flush squashes ID so no stall is due
  always_comb begin
    stall = 1'b0;
    if (idex_valid_q && idex_memread_q && idex_regwrite_q && (idex_dst_q != '0) &&
        id_valid_i && !flush_i &&
        ((idex_dst_q == id_rs_i) || (idex_dst_q == id_rt_i))) begin
      stall = 1'b1;
    end
  end

  always_comb begin
    idex_load        = id_valid_i && !stall && !flush_i;
    idex_valid_d     = idex_load;
    idex_rs_d        = idex_rs_q;
    idex_rt_d        = idex_rt_q;
    idex_dst_d       = idex_dst_q;
    idex_regwrite_d  = idex_regwrite_q;
    idex_memread_d   = idex_memread_q;
    if (idex_load) begin
      idex_rs_d       = id_rs_i;
      idex_rt_d       = id_rt_i;
      idex_dst_d      = id_dst_i;
      idex_regwrite_d = id_regwrite_i;
      idex_memread_d  = id_memread_i;
    end

    exmem_valid_d    = idex_valid_q;
    exmem_dst_d      = idex_dst_q;
    exmem_regwrite_d = idex_regwrite_q;

    memwb_valid_d    = exmem_valid_q;
    memwb_dst_d      = exmem_dst_q;
    memwb_regwrite_d = exmem_regwrite_q;

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      idex_valid_q  <= 1'b0;
      exmem_valid_q <= 1'b0;
      memwb_valid_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      idex_valid_q  <= idex_valid_d;
      exmem_valid_q <= exmem_valid_d;
      memwb_valid_q <= memwb_valid_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  // Payload fields are qualified by the valid bits and carry no reset
  always_ff @(posedge clk_i) begin
    idex_rs_q        <= idex_rs_d;
    idex_rt_q        <= idex_rt_d;
    idex_dst_q       <= idex_dst_d;
    idex_regwrite_q  <= idex_regwrite_d;
    idex_memread_q   <= idex_memread_d;
    exmem_dst_q      <= exmem_dst_d;
    exmem_regwrite_q <= exmem_regwrite_d;
    memwb_dst_q      <= memwb_dst_d;
    memwb_regwrite_q <= memwb_regwrite_d;
  end

  fwd_select #(.AW(REG_ADDR_W)) u_fwd_rs (
    .idex_valid_i     (idex_valid_q),
    .src_i            (idex_rs_q),
    .exmem_valid_i    (exmem_valid_q),
    .exmem_regwrite_i (exmem_regwrite_q),
    .exmem_dst_i      (exmem_dst_q),
    .memwb_valid_i    (memwb_valid_q),
    .memwb_regwrite_i (memwb_regwrite_q),
    .memwb_dst_i      (memwb_dst_q),
    .sel_o            (fwd_a_o)
  );

  fwd_select #(.AW(REG_ADDR_W)) u_fwd_rt (
    .idex_valid_i     (idex_valid_q),
    .src_i            (idex_rt_q),
    .exmem_valid_i    (exmem_valid_q),
    .exmem_regwrite_i (exmem_regwrite_q),
    .exmem_dst_i      (exmem_dst_q),
    .memwb_valid_i    (memwb_valid_q),
    .memwb_regwrite_i (memwb_regwrite_q),
    .memwb_dst_i      (memwb_dst_q),
    .sel_o            (fwd_b_o)
  );

  assign stall_o     = stall;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - scoreboard bench for hazard_forward_unit with directed instruction sequences
module tb_hazard_forward_unit;

  localparam int AW = 5;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          id_valid_i = 1'b0;
  logic [AW-1:0] id_rs_i = '0;
  logic [AW-1:0] id_rt_i = '0;
  logic [AW-1:0] id_dst_i = '0;
  logic          id_regwrite_i = 1'b0;
  logic          id_memread_i = 1'b0;
  logic          flush_i = 1'b0;
  logic [1:0]    fwd_a_o;
  logic [1:0]    fwd_b_o;
  logic          stall_o;
  logic [CW-1:0] stall_cnt_o;

  hazard_forward_unit #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .id_valid_i    (id_valid_i),
    .id_rs_i       (id_rs_i),
    .id_rt_i       (id_rt_i),
    .id_dst_i      (id_dst_i),
    .id_regwrite_i (id_regwrite_i),
    .id_memread_i  (id_memread_i),
    .flush_i       (flush_i),
    .fwd_a_o       (fwd_a_o),
    .fwd_b_o       (fwd_b_o),
    .stall_o       (stall_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]    a;
    logic [1:0]    b;
    logic          s;
    logic [CW-1:0] c;
    string         name;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cnt_model = 0;

  // One cycle: inputs at edge+1, reset level at edge+3, observation at the following falling edge
  task automatic step(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                      input logic [AW-1:0] dst, input logic rw, input logic mr, input logic fl,
                      input logic rv, input logic [1:0] ea, input logic [1:0] eb,
                      input logic es, input string nm);
    exp_t e;
    @(posedge clk_i);
    #1;
    id_valid_i    = v;
    id_rs_i       = rs;
    id_rt_i       = rt;
    id_dst_i      = dst;
    id_regwrite_i = rw;
    id_memread_i  = mr;
    flush_i       = fl;
    #2;
    rst_i = rv;
    if (!rv) cnt_model = 0;
    e.a = ea;
    e.b = eb;
    e.s = es;
    e.c = CW'(cnt_model);
    e.name = nm;
    q.push_back(e);
    if (es && cnt_model < CNT_MAX) cnt_model++;
  endtask

  task automatic ins(input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] dst,
                     input logic rw, input logic mr, input logic [1:0] ea, input logic [1:0] eb,
                     input logic es, input string nm);
    step(1'b1, rs, rt, dst, rw, mr, 1'b0, 1'b1, ea, eb, es, nm);
  endtask

  task automatic nopx(input logic [1:0] ea, input logic [1:0] eb, input string nm);
    step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, ea, eb, 1'b0, nm);
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 3; i++) nopx(2'b00, 2'b00, nm);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if ({fwd_a_o, fwd_b_o, stall_o, stall_cnt_o} !== {e.a, e.b, e.s, e.c}) begin
          bad++;
          $display("FAIL %s: got a=%b b=%b stall=%b cnt=%0d, want a=%b b=%b stall=%b cnt=%0d",
                   e.name, fwd_a_o, fwd_b_o, stall_o, stall_cnt_o, e.a, e.b, e.s, e.c);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want test completion");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, "reset0");
    step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, "reset1");
    nopx(2'b00, 2'b00, "release");

    // add $3,$1,$2 ; add $4,$3,$5
    ins(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, "raw_add3");
    ins(5'd3, 5'd5, 5'd4, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, "raw_add4");
    nopx(2'b10, 2'b00, "raw_ex_fwd");
    drain("raw_drain");

    // add $3 ; nop ; sub $6,$7,$3 then two $3 writers back to back
    ins(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, "wb_add3");
    nopx(2'b00, 2'b00, "wb_gap");
    ins(5'd7, 5'd3, 5'd6, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, "wb_sub");
    nopx(2'b00, 2'b01, "wb_fwd_b");
    ins(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, "nw_add3_1");
    ins(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, "nw_add3_2");
    ins(5'd7, 5'd3, 5'd6, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, "nw_sub");
    nopx(2'b00, 2'b10, "newer_wins");
    drain("nw_drain");
    nopx(2'b00, 2'b00, "nw_drain");

    // lw $2 ; add $4,$2,$2
    ins(5'd1, 5'd2, 5'd2, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, "lu_lw");
    ins(5'd2, 5'd2, 5'd4, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, "load_use_stall");
    ins(5'd2, 5'd2, 5'd4, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, "stall_once");
    nopx(2'b01, 2'b01, "load_fwd");
    drain("lu_drain");

    // writes to $0 then readers of $0
    ins(5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, "r0_add");
    ins(5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, "r0_lw");
    ins(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, "r0_no_stall");
    nopx(2'b00, 2'b00, "r0_no_fwd");
    drain("r0_drain");

    // load-use hazard with flush in the same cycle
    ins(5'd1, 5'd2, 5'd2, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, "fl_lw");
    step(1'b1, 5'd2, 5'd2, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, "flush_wins");
    ins(5'd2, 5'd2, 5'd4, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, "flush_bubble");
    nopx(2'b01, 2'b01, "fl_after");
    drain("fl_drain");

    // reset asserted while a load-use stall is being presented
    ins(5'd1, 5'd2, 5'd2, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, "rm_lw");
    step(1'b1, 5'd2, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, "rst_mid_stall");
    ins(5'd2, 5'd2, 5'd4, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, "rst_empty");
    nopx(2'b00, 2'b00, "post_rst");
    drain("rm_drain");

    // 2^CNT_W+3 forced stalls
    for (int i = 0; i < CNT_MAX + 4; i++) begin
      ins(5'd1, 5'd2, 5'd2, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, "sat_lw");
      ins(5'd2, 5'd2, 5'd4, 1'b1, 1'b0, 2'b00, (i == 0) ? 2'b00 : 2'b01, 1'b1, "sat_stall");
    end
    nopx(2'b00, 2'b00, "sat_15");

    @(posedge clk_i);
    @(negedge clk_i);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_empty: got %0d pending, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
